// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the pipeline MEM stage (CPU
// port) and a secondary DMA / debug-loader master. The CPU wins by default.
// A wait counter tracks how long a pending DMA request has been denied. Once
// it reaches MAX_WAIT the DMA is forced onto the memory for a burst of up to
// BURST_MAX cycles, and the MEM stage is stalled for that burst.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   cpu_req/flush     MEM-stage request; a flushed request is ignored
//   cpu_we/op/addr/wdata  CPU access attributes
//   cpu_rdata         load data, straight from mem_rdata
//   cpu_stall         MEM-stage access was not performed this cycle
//   dma_req/we/op/addr/wdata  DMA access attributes (req held until granted)
//   dma_gnt           DMA access performed this cycle
//   dma_rdata/rvalid  registered DMA read data, valid the cycle after a grant
//   mem_we/op/addr/wdata  drive the data memory
//   mem_rdata         combinational read data from the data memory
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_flush,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_op,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [1:0]        dma_op,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              mem_we,
   output logic [1:0]        mem_op,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [WW-1:0] WAIT_TOP   = WW'(MAX_WAIT);
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

   typedef enum logic {
      CPU_PRI,
      DMA_BURST
   } state_t;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic [BW-1:0] burst_cnt;
   logic          creq;
   logic          forced;

   // A flushed MEM-stage instruction must not touch memory, so the flush
   // masks the request before any arbitration happens.
   assign creq   = cpu_req & ~cpu_flush;
   assign forced = (state == CPU_PRI) & creq & dma_req & (wait_cnt == WAIT_TOP);

   // Grant/stall decode. In CPU_PRI the DMA only gets idle CPU cycles unless
   // it has been starved long enough; in DMA_BURST it keeps the memory for as
   // long as it keeps requesting.
   always_comb begin
      dma_gnt   = 1'b0;
      cpu_stall = 1'b0;
      case (state)
         CPU_PRI: begin
            dma_gnt   = dma_req & (~creq | forced);
            cpu_stall = forced;
         end
         DMA_BURST: begin
            dma_gnt   = dma_req;
            cpu_stall = creq & dma_req;
         end
         default: begin
            dma_gnt   = 1'b0;
            cpu_stall = 1'b0;
         end
      endcase
   end

   // Memory-side mux. The store enable from the CPU side uses creq so that a
   // flushed store never writes.
   assign mem_we    = dma_gnt ? dma_we    : (creq & cpu_we);
   assign mem_op    = dma_gnt ? dma_op    : cpu_op;
   assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
   assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
   assign cpu_rdata = mem_rdata;

   // Starvation tracking and burst sequencing. wait_cnt only counts cycles in
   // which the DMA was denied because the CPU was using the memory; any idle
   // DMA cycle or actual DMA grant restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= CPU_PRI;
         wait_cnt  <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            CPU_PRI: begin
               if (!dma_req || !creq) begin
                  wait_cnt <= '0;
               end else if (wait_cnt != WAIT_TOP) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end else begin
                  wait_cnt <= '0;
                  if (BURST_MAX > 1) begin
                     state     <= DMA_BURST;
                     burst_cnt <= BW'(1);
                  end else begin
                     burst_cnt <= '0;
                  end
               end
            end
            DMA_BURST: begin
               if (dma_req && (burst_cnt != BURST_LAST)) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end else begin
                  state     <= CPU_PRI;
                  burst_cnt <= '0;
               end
            end
            default: begin
               state     <= CPU_PRI;
               burst_cnt <= '0;
            end
         endcase
      end
   end

   // DMA read return: capture the memory data on the edge that closes a read
   // grant, so the DMA sees it one cycle later; writes produce no rvalid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dma_rdata  <= '0;
         dma_rvalid <= 1'b0;
      end else begin
         dma_rvalid <= dma_gnt & ~dma_we;
         if (dma_gnt && !dma_we) begin
            dma_rdata <= mem_rdata;
         end
      end
   end

endmodule
